glb_rd_fetch: RTL and testbench

Read-side client for one global-buffer (GLB) read port running in address mode. It accepts a job descriptor (base address and word count) and issues consecutive word addresses on the GLB read-address channel. Read data beats are collected into a credit-controlled skid FIFO and forwarded in order to a downstream consumer (PE array / pooling front end) with a last-beat marker. It sits between the CCU-programmed datapath engines and a GLB read port.

---
 rtl/glb_rd_fetch.sv | 165 ++++++++++++++++
 tb/tb_glb_rd_fetch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_rd_fetch.sv
// glb_rd_fetch: read-side client for one GLB read port in address mode.
// Takes a (base, count) job descriptor and issues consecutive word addresses.
// It collects the returned beats in a credit-controlled skid FIFO and
// forwards them in order to the consumer, marking the final beat.
// Optional feature macro: GLB_RD_FETCH_BYPASS_EN. When it is defined, a beat
// that arrives while the FIFO is empty and the consumer is ready goes straight
// to the output in the same cycle.
//
// Handshake rule for every channel (Cfg, RdPortAddr, RdPortDat, OutDat):
// a transfer happens on the rising edge where Vld and Rdy are both high.
// The sender holds payload and Vld stable until that edge.
// The receiver may raise or drop Rdy at any time.
module glb_rd_fetch #(
  parameter int ADDR_WIDTH = 16,
  parameter int DAT_WIDTH  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CfgVld,
  output logic                  CfgRdy,
  input  logic [ADDR_WIDTH-1:0] CfgBaseAddr,
  input  logic [ADDR_WIDTH-1:0] CfgNum,
  output logic [ADDR_WIDTH-1:0] RdPortAddr,
  output logic                  RdPortAddrVld,
  input  logic                  RdPortAddrRdy,
  input  logic [DAT_WIDTH-1:0]  RdPortDat,
  input  logic                  RdPortDatVld,
  output logic                  RdPortDatRdy,
  output logic [DAT_WIDTH-1:0]  OutDat,
  output logic                  OutDatVld,
  output logic                  OutDatLast,
  input  logic                  OutDatRdy,
  output logic                  Busy,
  output logic                  Done,
  output logic [1:0]            dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_F = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_r;
  logic [ADDR_WIDTH-1:0] num_r;
  logic [ADDR_WIDTH-1:0] idx_i;
  logic [ADDR_WIDTH-1:0] idx_k;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic                  done_r;

  // Credits: cnt_o counts reads in flight and cnt_f counts FIFO occupancy.
  logic [CW-1:0]         cnt_o;
  logic [CW-1:0]         cnt_f;
  logic [CW:0]           credit_sum;
  logic [DAT_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  logic cfg_hs, addr_hs, dat_hs, dat_acc, push, pop, out_hs, byp_vld;
  logic fifo_empty, fifo_full;

  assign last_idx   = num_r - ADDR_WIDTH'(1);
  assign fifo_empty = (cnt_f == '0);
  assign fifo_full  = (cnt_f == DEPTH_F);
  assign credit_sum = {1'b0, cnt_o} + {1'b0, cnt_f};

  assign CfgRdy        = (state == ST_IDLE);
  assign Busy          = (state != ST_IDLE);
  assign Done          = done_r;
  assign dbg_state     = state;
  assign RdPortAddr    = base_r + idx_i;
  assign RdPortAddrVld = (state == ST_FETCH) && (credit_sum < DEPTH_C);
  assign RdPortDatRdy  = !fifo_full;

  assign cfg_hs  = CfgVld && CfgRdy;
  assign addr_hs = RdPortAddrVld && RdPortAddrRdy;
  assign dat_hs  = RdPortDatVld && RdPortDatRdy;
  // A beat with no read in flight is stale, for example left over from a
  // reset. It is accepted on the port and discarded.
  assign dat_acc = dat_hs && (cnt_o != '0);

`ifdef GLB_RD_FETCH_BYPASS_EN
  assign byp_vld   = dat_acc && fifo_empty && OutDatRdy;
  assign OutDat    = byp_vld ? RdPortDat : mem[rd_ptr];
`else
  assign byp_vld   = 1'b0;
  assign OutDat    = mem[rd_ptr];
`endif

  assign push       = dat_acc && !byp_vld;
  assign pop        = !fifo_empty && OutDatRdy;
  assign OutDatVld  = !fifo_empty || byp_vld;
  assign out_hs     = OutDatVld && OutDatRdy;
  assign OutDatLast = OutDatVld && (idx_k == last_idx);

  // Job FSM: latch the descriptor, step the address and output indices, and pulse Done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      base_r <= '0;
      num_r  <= '0;
      idx_i  <= '0;
      idx_k  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_hs) begin
            base_r <= CfgBaseAddr;
            num_r  <= CfgNum;
            idx_i  <= '0;
            idx_k  <= '0;
            if (CfgNum != '0) state  <= ST_FETCH;
            else              done_r <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (addr_hs) begin
            idx_i <= idx_i + ADDR_WIDTH'(1);
            if (idx_i == last_idx) state <= ST_DRAIN;
          end
          if (out_hs) idx_k <= idx_k + ADDR_WIDTH'(1);
        end
        ST_DRAIN: begin
          if (out_hs) begin
            idx_k <= idx_k + ADDR_WIDTH'(1);
            if (idx_k == last_idx) begin
              state  <= ST_IDLE;
              done_r <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Credit counters and skid FIFO. Same-cycle events combine into one net update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_o  <= '0;
      cnt_f  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int n = 0; n < FIFO_DEPTH; n++) mem[n] <= '0;
    end else begin
      cnt_o <= cnt_o + CW'(addr_hs) - CW'(dat_acc);
      cnt_f <= cnt_f + CW'(push) - CW'(pop);
      if (push) begin
        mem[wr_ptr] <= RdPortDat;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: tb/tb_glb_rd_fetch.sv
// tb_glb_rd_fetch: randomized bench for glb_rd_fetch with a GLB port model,
// a consumer model and a job-level reference model (expected address and
// data queues). Honours GLB_RD_FETCH_BYPASS_EN for the latency expectations.
module tb_glb_rd_fetch;

  localparam int AW = 16;
  localparam int DW = 256;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CfgVld = 1'b0;
  logic          CfgRdy;
  logic [AW-1:0] CfgBaseAddr = '0;
  logic [AW-1:0] CfgNum = '0;
  logic [AW-1:0] RdPortAddr;
  logic          RdPortAddrVld;
  logic          RdPortAddrRdy = 1'b0;
  logic [DW-1:0] RdPortDat = '0;
  logic          RdPortDatVld = 1'b0;
  logic          RdPortDatRdy;
  logic [DW-1:0] OutDat;
  logic          OutDatVld;
  logic          OutDatLast;
  logic          OutDatRdy = 1'b0;
  logic          Busy;
  logic          Done;
  logic [1:0]    dbg_state;

  glb_rd_fetch #(.ADDR_WIDTH(AW), .DAT_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n),
    .CfgVld(CfgVld), .CfgRdy(CfgRdy), .CfgBaseAddr(CfgBaseAddr), .CfgNum(CfgNum),
    .RdPortAddr(RdPortAddr), .RdPortAddrVld(RdPortAddrVld), .RdPortAddrRdy(RdPortAddrRdy),
    .RdPortDat(RdPortDat), .RdPortDatVld(RdPortDatVld), .RdPortDatRdy(RdPortDatRdy),
    .OutDat(OutDat), .OutDatVld(OutDatVld), .OutDatLast(OutDatLast), .OutDatRdy(OutDatRdy),
    .Busy(Busy), .Done(Done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  int addr_rdy_pct = 100;
  int dat_vld_pct  = 100;
  int out_rdy_pct  = 100;
  int out_rdy_mode = 1;      // 0 random, 1 always ready, 2 never ready
  int lat_min      = 1;
  int lat_max      = 1;
  bit chk_lat      = 1'b0;

  // ---------------- reference model state ----------------
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] glb_dat[$];
  int            glb_due[$];
  bit            glb_stale[$];
  int            cyc = 0;
  int            issued, delivered, accepted, out_since_rst;
  int            first_addr_cyc, last_addr_cyc;
  bit            done_pend, busy_m, lat_next, prev_hold, done_next;
  bit            beat_taken, beat_stale;
  logic [AW-1:0] prev_addr;
  logic [15:0]   cur_salt;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a, input logic [15:0] s);
    return {8{s, a}};
  endfunction

  // ---------------- GLB and consumer drivers ----------------
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    RdPortAddrRdy = ($urandom_range(99) < addr_rdy_pct);
    if (glb_dat.size() > 0 && glb_due[0] <= cyc && $urandom_range(99) < dat_vld_pct) begin
      RdPortDatVld = 1'b1;
      RdPortDat    = glb_dat[0];
    end else begin
      RdPortDatVld = 1'b0;
      RdPortDat    = '0;
    end
    case (out_rdy_mode)
      1:       OutDatRdy = 1'b1;
      2:       OutDatRdy = 1'b0;
      default: OutDatRdy = ($urandom_range(99) < out_rdy_pct);
    endcase
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    beat_taken = RdPortDatVld && RdPortDatRdy;
    beat_stale = 1'b1;
    if (beat_taken && glb_dat.size() > 0) begin
      beat_stale = glb_stale[0];
      void'(glb_dat.pop_front());
      void'(glb_due.pop_front());
      void'(glb_stale.pop_front());
    end
    if (!rst_n) begin
      exp_addr_q.delete();
      exp_q.delete();
      issued = 0; delivered = 0; accepted = 0; out_since_rst = 0;
      done_pend = 0; busy_m = 0; lat_next = 0; prev_hold = 0;
      foreach (glb_stale[j]) glb_stale[j] = 1'b1;
    end else begin
      check("done", Done, done_pend);
      check("busy", Busy, busy_m);
      check("cfg_rdy", CfgRdy, !busy_m);
      done_next = 1'b0;
      if (lat_next) check("lat_fifo_vld", OutDatVld, 1);
      lat_next = 1'b0;
      if (prev_hold) begin
        check("addr_hold_vld", RdPortAddrVld, 1);
        check("addr_hold", RdPortAddr, prev_addr);
      end
      prev_hold = RdPortAddrVld && !RdPortAddrRdy;
      prev_addr = RdPortAddr;

      if (CfgVld && CfgRdy) begin
        cur_salt = 16'($urandom);
        issued = 0; delivered = 0; accepted = 0;
        for (int i = 0; i < int'(CfgNum); i++) begin
          exp_addr_q.push_back(AW'(CfgBaseAddr + AW'(i)));
          exp_q.push_back(data_of(AW'(CfgBaseAddr + AW'(i)), cur_salt));
        end
        if (CfgNum == '0) done_next = 1'b1;
        else busy_m = 1'b1;
      end

      if (RdPortAddrVld && RdPortAddrRdy) begin
        if (exp_addr_q.size() == 0) check("addr_extra", RdPortAddr, ~RdPortAddr);
        else check("addr", RdPortAddr, exp_addr_q.pop_front());
        check("credit", (issued - delivered) < FD, 1);
        if (issued == 0) first_addr_cyc = cyc;
        last_addr_cyc = cyc;
        issued++;
        glb_dat.push_back(data_of(RdPortAddr, cur_salt));
        glb_due.push_back(cyc + lat_min + int'($urandom_range(lat_max - lat_min)));
        glb_stale.push_back(1'b0);
      end

      if (beat_taken && !beat_stale) begin
        if (chk_lat && accepted == delivered && OutDatRdy) begin
`ifdef GLB_RD_FETCH_BYPASS_EN
          check("lat_bypass_vld", OutDatVld, 1);
`else
          check("lat_fifo_early", OutDatVld, 0);
          lat_next = 1'b1;
`endif
        end
        accepted++;
      end

      if (OutDatVld && OutDatRdy) begin
        out_since_rst++;
        if (exp_q.size() == 0) check("out_extra", OutDat, ~OutDat);
        else begin
          check("out_last", OutDatLast, exp_q.size() == 1);
          check("out_dat", OutDat, exp_q.pop_front());
          delivered++;
          if (exp_q.size() == 0) begin
            done_next = 1'b1;
            busy_m    = 1'b0;
          end
        end
      end
      done_pend = done_next;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_cfg_rdy",  CfgRdy, 1);
    check("rst_addr",     RdPortAddr, 0);
    check("rst_addr_vld", RdPortAddrVld, 0);
    check("rst_dat_rdy",  RdPortDatRdy, 1);
    check("rst_out_dat",  OutDat, 0);
    check("rst_out_vld",  OutDatVld, 0);
    check("rst_out_last", OutDatLast, 0);
    check("rst_busy",     Busy, 0);
    check("rst_done",     Done, 0);
    check("rst_state",    dbg_state, 0);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic start_job(input logic [AW-1:0] b, input logic [AW-1:0] n);
    int t = 0;
    @(posedge clk); #1;
    CfgVld = 1'b1; CfgBaseAddr = b; CfgNum = n;
    do begin @(negedge clk); t++; end while (!CfgRdy && t < 50);
    check("cfg_accept", CfgRdy, 1);
    @(posedge clk); #1;
    CfgVld = 1'b0; CfgBaseAddr = AW'($urandom); CfgNum = AW'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(negedge clk); #1; n++; end while ((exp_q.size() != 0 || busy_m) && n < budget);
    check("job_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    do_reset();

    // Basic: three words, latency 1, consumer always ready.
    chk_lat = 1'b1; out_rdy_mode = 1; addr_rdy_pct = 100; dat_vld_pct = 100;
    lat_min = 1; lat_max = 1;
    start_job(16'h0010, 16'd3);
    wait_idle(200);
    check("basic_issued", issued, 3);
    check("basic_back_to_back", last_addr_cyc - first_addr_cyc, 2);
    chk_lat = 1'b0;

    // Backpressure: consumer stalled, credits cap the outstanding reads.
    out_rdy_mode = 2;
    start_job(16'h0200, 16'd8);
    repeat (20) @(negedge clk);
    #1;
    check("bp_issued", issued, FD);
    check("bp_addr_vld", RdPortAddrVld, 0);
    out_rdy_mode = 1;
    wait_idle(300);
    check("bp_delivered", delivered, 8);

    // Address wrap at the top of the address space.
    start_job(16'hFFFE, 16'd4);
    wait_idle(200);
    check("wrap_delivered", delivered, 4);

    // Zero-length job: Done the next cycle, never busy, no address.
    start_job(16'h1234, 16'd0);
    @(negedge clk);
    check("zero_done", Done, 1);
    check("zero_busy", Busy, 0);
    check("zero_addr_vld", RdPortAddrVld, 0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a job, then late GLB beats must be dropped.
    out_rdy_mode = 0; out_rdy_pct = 50; lat_min = 2; lat_max = 4;
    start_job(16'h0400, 16'd16);
    begin
      int t = 0;
      do begin @(negedge clk); #1; t++; end while (issued < 5 && t < 200);
      check("mid_reset_reached", issued >= 5, 1);
    end
    do_reset();
    out_rdy_mode = 1;
    begin
      int t = 0;
      do begin @(negedge clk); #1; t++; end while (glb_dat.size() != 0 && t < 200);
      check("late_beats_drained", glb_dat.size(), 0);
      check("late_beats_dropped", out_since_rst, 0);
    end
    start_job(16'h0500, 16'd6);
    wait_idle(300);
    check("post_reset_delivered", delivered, 6);

    // Randomized jobs with random GLB latency and handshake stalls.
    for (int j = 0; j < 12; j++) begin
      addr_rdy_pct = $urandom_range(100, 30);
      dat_vld_pct  = $urandom_range(100, 30);
      out_rdy_mode = $urandom_range(1, 0);
      out_rdy_pct  = $urandom_range(100, 20);
      lat_min      = $urandom_range(3, 1);
      lat_max      = lat_min + $urandom_range(3, 0);
      start_job(AW'($urandom), AW'($urandom_range(24, (j == 5) ? 0 : 1)));
      wait_idle(2000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog: the sequence above is bounded, this only guards against a stuck run.
  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
